// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit and its byte-lane helper.
// Operation encoding, FSM states, byte-enable constants.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LS_LW  = 2'd0,
        LS_LBU = 2'd1,
        LS_SW  = 2'd2,
        LS_SB  = 2'd3
    } ls_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam int         BYTE_LANES = 4;

    function automatic logic is_store(input ls_op_e op);
        return (op == LS_SW) || (op == LS_SB);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian byte-lane steering: store byte enables/replicated data, LBU extraction.
// Purely combinational, zero latency; no flow control.
module lsu_byte_lane
    import load_store_unit_pkg::*;
(
    input  ls_op_e      st_op,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  ls_op_e      ld_op,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        if (st_op == LS_SB) begin
            st_be    = 4'b0001 << st_lane;
            st_wdata = {BYTE_LANES{st_data[7:0]}};
        end

        ld_data = ld_rdata;
        if (ld_op == LS_LBU) begin
            ld_data = {24'b0, ld_rdata[{ld_lane, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and data memory; LSU_ALIGN_CHECK_EN traps misaligned LW/SW.
// Load: accept->wb_valid in 3 cycles minimum; store: accept->st_done in 2 cycles.
// Backpressure: req_ready_o only in IDLE; mem request fields held while mem_req_ready_i is low.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  ls_op_e            req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [TAG_W-1:0]  req_rd_i,
    output logic              busy_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              wb_valid_o,
    output logic [TAG_W-1:0]  wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              st_done_o,
    output logic              align_err_o
);

    lsu_state_e        state_q, state_d;
    ls_op_e            op_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [TAG_W-1:0]  rd_q;
    logic              wb_valid_q;
    logic [TAG_W-1:0]  wb_rd_q;
    logic [31:0]       wb_data_q;
    logic              st_done_q;

    logic              accept;
    logic              st_fire;
    logic              ld_rsp;
    logic              misaligned;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    lsu_byte_lane u_byte_lane (
        .st_op    (req_op_i),
        .st_lane  (req_addr_i[1:0]),
        .st_data  (req_wdata_i),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_op    (op_q),
        .ld_lane  (lane_q),
        .ld_rdata (mem_rdata_i),
        .ld_data  (ld_data)
    );

`ifdef LSU_ALIGN_CHECK_EN
    logic align_err_q;

    assign misaligned  = ((req_op_i == LS_LW) || (req_op_i == LS_SW)) && (req_addr_i[1:0] != 2'b00);
    assign align_err_o = align_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= accept && misaligned;
        end
    end
`else
    assign misaligned  = 1'b0;
    assign align_err_o = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        st_fire         = 1'b0;
        ld_rsp          = 1'b0;
        req_ready_o     = 1'b0;
        busy_o          = 1'b1;
        mem_req_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    // A trapped access never reaches memory.
                    state_d = misaligned ? IDLE : REQ;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    if (is_store(op_q)) begin
                        st_fire = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    ld_rsp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= LS_LW;
            lane_q     <= 2'b00;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'b0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= 32'b0;
            st_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= ld_rsp;
            st_done_q  <= st_fire;
            if (accept) begin
                op_q    <= req_op_i;
                lane_q  <= req_addr_i[1:0];
                addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                be_q    <= st_be;
                wdata_q <= st_wdata;
                we_q    <= is_store(req_op_i);
                rd_q    <= req_rd_i;
            end
            if (ld_rsp) begin
                wb_data_q <= ld_data;
                wb_rd_q   <= rd_q;
            end
        end
    end

    // Memory-side fields read as zero whenever no request is being presented.
    assign mem_addr_o  = mem_req_valid_o ? addr_q  : '0;
    assign mem_we_o    = mem_req_valid_o ? we_q    : 1'b0;
    assign mem_be_o    = mem_req_valid_o ? be_q    : 4'b0000;
    assign mem_wdata_o = mem_req_valid_o ? wdata_q : 32'b0;

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign st_done_o  = st_done_q;

endmodule
